// File: rtl/l1_cache_control_if.sv
// CPU-side and pmem-side handshake bundle for the L1 cache controller.
// The controller uses the slave view; the CPU/pmem environment uses master.
interface l1_cache_control_if #(
  parameter int s_offset = 5
);
  localparam int s_mask = 2**s_offset;

  logic              mem_read;
  logic              mem_write;
  logic [s_mask-1:0] mem_byte_enable;
  logic              mem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic              pmem_addr_sel;
  logic              pmem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel
  );
endinterface

// File: rtl/l1_cache_control.sv
// Control FSM for a 2-way set-associative, write-back, write-allocate L1 cache.
// Hits complete in the request cycle; misses optionally write back the dirty
// victim, fill the line from pmem, then let the held request retry as a hit.
module l1_cache_control #(
  parameter int s_offset = 5,
  parameter int s_cnt    = 32
) (
  input  logic                clk,
  input  logic                rst,
  l1_cache_control_if.slave   bus,
  input  logic                hit0,
  input  logic                hit1,
  input  logic                dirty0,
  input  logic                dirty1,
  input  logic                lru,
  output logic                victim,
  output logic [2**s_offset-1:0] way0_we,
  output logic [2**s_offset-1:0] way1_we,
  output logic                data_sel,
  output logic                tag_load0,
  output logic                tag_load1,
  output logic                dirty_set0,
  output logic                dirty_set1,
  output logic                dirty_clr0,
  output logic                dirty_clr1,
  output logic                lru_load,
  output logic                lru_in,
  output logic [s_cnt-1:0]    hit_cnt,
  output logic [s_cnt-1:0]    miss_cnt,
  output logic [s_cnt-1:0]    wb_cnt
);
  localparam int s_mask = 2**s_offset;
  localparam logic [s_cnt-1:0]  cnt_one   = {{(s_cnt-1){1'b0}}, 1'b1};
  localparam logic [s_cnt-1:0]  cnt_zero  = {s_cnt{1'b0}};
  localparam logic [s_mask-1:0] mask_zero = {s_mask{1'b0}};
  localparam logic [s_mask-1:0] mask_ones = {s_mask{1'b1}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic request;
  logic is_write;
  logic hit_way;
  logic lru_dirty;
  logic hit_evt;
  logic miss_evt;
  logic wb_evt;

  // A simultaneous read and write is served as a write; way 0 wins a double hit.
  assign request   = bus.mem_read | bus.mem_write;
  assign is_write  = bus.mem_write;
  assign hit_way   = hit0 ? 1'b0 : 1'b1;
  assign lru_dirty = lru ? dirty1 : dirty0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and all combinational controls; everything is forced low during rst.
  always_comb begin
    next_state        = state;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    way0_we           = mask_zero;
    way1_we           = mask_zero;
    data_sel          = 1'b0;
    tag_load0         = 1'b0;
    tag_load1         = 1'b0;
    dirty_set0        = 1'b0;
    dirty_set1        = 1'b0;
    dirty_clr0        = 1'b0;
    dirty_clr1        = 1'b0;
    lru_load          = 1'b0;
    lru_in            = 1'b0;
    hit_evt           = 1'b0;
    miss_evt          = 1'b0;
    wb_evt            = 1'b0;
    if (rst) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (request && (hit0 || hit1)) begin
            bus.mem_resp = 1'b1;
            lru_load     = 1'b1;
            lru_in       = ~hit_way;
            hit_evt      = 1'b1;
            if (is_write && hit_way) begin
              way1_we    = bus.mem_byte_enable;
              dirty_set1 = 1'b1;
            end else if (is_write) begin
              way0_we    = bus.mem_byte_enable;
              dirty_set0 = 1'b1;
            end else begin
              way0_we = mask_zero;
            end
          end else if (request) begin
            miss_evt   = 1'b1;
            next_state = lru_dirty ? WRITEBACK : FILL;
          end else begin
            next_state = IDLE;
          end
        end
        WRITEBACK: begin
          bus.pmem_write    = 1'b1;
          bus.pmem_addr_sel = 1'b1;
          if (bus.pmem_resp) begin
            dirty_clr0 = ~victim;
            dirty_clr1 = victim;
            wb_evt     = 1'b1;
            next_state = FILL;
          end else begin
            next_state = WRITEBACK;
          end
        end
        FILL: begin
          bus.pmem_read = 1'b1;
          if (bus.pmem_resp) begin
            way0_we    = victim ? mask_zero : mask_ones;
            way1_we    = victim ? mask_ones : mask_zero;
            data_sel   = 1'b1;
            tag_load0  = ~victim;
            tag_load1  = victim;
            dirty_clr0 = ~victim;
            dirty_clr1 = victim;
            next_state = IDLE;
          end else begin
            next_state = FILL;
          end
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // Victim capture on a miss and wrapping performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      victim   <= 1'b0;
      hit_cnt  <= cnt_zero;
      miss_cnt <= cnt_zero;
      wb_cnt   <= cnt_zero;
    end else begin
      if (miss_evt) begin
        victim <= lru;
      end else begin
        victim <= victim;
      end
      if (hit_evt) begin
        hit_cnt <= hit_cnt + cnt_one;
      end else begin
        hit_cnt <= hit_cnt;
      end
      if (miss_evt) begin
        miss_cnt <= miss_cnt + cnt_one;
      end else begin
        miss_cnt <= miss_cnt;
      end
      if (wb_evt) begin
        wb_cnt <= wb_cnt + cnt_one;
      end else begin
        wb_cnt <= wb_cnt;
      end
    end
  end
endmodule

// File: tb/tb_l1_cache_control.sv
// Bench for l1_cache_control: directed scenarios plus randomized transactions,
// each cycle's controls compared against expectations derived from the
// transaction being performed, counters tracked as plain integers.
module tb_l1_cache_control;
  localparam int S_OFF = 5;
  localparam int S_CNT = 4;
  localparam int MASK  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1_cache_control_if #(.s_offset(S_OFF)) bus ();

  logic hit0, hit1, dirty0, dirty1, lru, victim;
  logic [MASK-1:0] way0_we, way1_we;
  logic data_sel, tag_load0, tag_load1, dirty_set0, dirty_set1;
  logic dirty_clr0, dirty_clr1, lru_load, lru_in;
  logic [S_CNT-1:0] hit_cnt, miss_cnt, wb_cnt;

  l1_cache_control #(.s_offset(S_OFF), .s_cnt(S_CNT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1), .lru(lru),
    .victim(victim), .way0_we(way0_we), .way1_we(way1_we), .data_sel(data_sel),
    .tag_load0(tag_load0), .tag_load1(tag_load1),
    .dirty_set0(dirty_set0), .dirty_set1(dirty_set1),
    .dirty_clr0(dirty_clr0), .dirty_clr1(dirty_clr1),
    .lru_load(lru_load), .lru_in(lru_in),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  typedef struct packed {
    logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel;
    logic tag_load0, tag_load1, dirty_set0, dirty_set1, dirty_clr0, dirty_clr1;
    logic lru_load, lru_in;
    logic [MASK-1:0] way0_we, way1_we;
  } outs_t;

  outs_t obs;
  assign obs = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel, data_sel,
                tag_load0, tag_load1, dirty_set0, dirty_set1, dirty_clr0, dirty_clr1,
                lru_load, lru_in, way0_we, way1_we};

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int n_hit  = 0;
  int n_miss = 0;
  int n_wb   = 0;

  task automatic chk(input string tag, input logic [79:0] o, input logic [79:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_outs(input string tag, input outs_t e);
    chk(tag, 80'(obs), 80'(e));
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_hit_cnt"},  80'(hit_cnt),  80'(n_hit % 16));
    chk({tag, "_miss_cnt"}, 80'(miss_cnt), 80'(n_miss % 16));
    chk({tag, "_wb_cnt"},   80'(wb_cnt),   80'(n_wb % 16));
  endtask

  function automatic outs_t e_hit(input bit wr, input logic [MASK-1:0] be, input bit way);
    outs_t e = '0;
    e.mem_resp = 1'b1;
    e.lru_load = 1'b1;
    e.lru_in   = ~way;
    if (wr && way) begin
      e.way1_we = be; e.dirty_set1 = 1'b1;
    end else if (wr) begin
      e.way0_we = be; e.dirty_set0 = 1'b1;
    end
    return e;
  endfunction

  function automatic outs_t e_wb(input bit v, input bit done);
    outs_t e = '0;
    e.pmem_write    = 1'b1;
    e.pmem_addr_sel = 1'b1;
    if (done) begin
      e.dirty_clr0 = ~v; e.dirty_clr1 = v;
    end
    return e;
  endfunction

  function automatic outs_t e_fill(input bit v, input bit done);
    outs_t e = '0;
    e.pmem_read = 1'b1;
    if (done) begin
      if (v) e.way1_we = '1; else e.way0_we = '1;
      e.data_sel  = 1'b1;
      e.tag_load0 = ~v; e.tag_load1 = v;
      e.dirty_clr0 = ~v; e.dirty_clr1 = v;
    end
    return e;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = '0;
    bus.pmem_resp = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
  endtask

  // No request: everything stays low even if pmem_resp or hits wiggle.
  task automatic idle_cyc();
    idle_inputs();
    bus.pmem_resp = 1'($urandom);
    hit0 = 1'($urandom); hit1 = 1'($urandom);
    settle();
    chk_outs("idle", '0);
    next_cyc();
    idle_inputs();
  endtask

  // One CPU transaction from request to response (or to fill end when dropped).
  task automatic txn(input bit wr, input bit rd_too, input logic [MASK-1:0] be,
                     input bit h0, input bit h1, input bit lru_v, input bit d0, input bit d1,
                     input int wb_lat, input int fill_lat, input bit drop);
    bit v;
    bit dv;
    bus.mem_write = wr;
    bus.mem_read  = !wr || rd_too;
    bus.mem_byte_enable = be;
    bus.pmem_resp = 1'b0;
    lru = lru_v; dirty0 = d0; dirty1 = d1;
    if (h0 || h1) begin
      hit0 = h0; hit1 = h1;
      settle();
      chk_outs("hit", e_hit(wr, be, h0 ? 1'b0 : 1'b1));
      next_cyc();
      n_hit++;
    end else begin
      hit0 = 1'b0; hit1 = 1'b0;
      v  = lru_v;
      dv = lru_v ? d1 : d0;
      settle();
      chk_outs("miss_start", '0);
      next_cyc();
      n_miss++;
      chk("victim", 80'(victim), 80'(v));
      if (drop) begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      end
      if (dv) begin
        for (int c = 1; c <= wb_lat; c++) begin
          bus.pmem_resp = (c == wb_lat);
          hit0 = 1'($urandom); hit1 = 1'($urandom); lru = 1'($urandom);
          settle();
          chk_outs("writeback", e_wb(v, c == wb_lat));
          next_cyc();
        end
        n_wb++;
      end
      for (int c = 1; c <= fill_lat; c++) begin
        bus.pmem_resp = (c == fill_lat);
        hit0 = 1'($urandom); hit1 = 1'($urandom); lru = 1'($urandom);
        settle();
        chk_outs("fill", e_fill(v, c == fill_lat));
        next_cyc();
      end
      bus.pmem_resp = 1'b0;
      if (!drop) begin
        hit0 = !v; hit1 = v;
        settle();
        chk_outs("retry_hit", e_hit(wr, be, v));
        next_cyc();
        n_hit++;
      end else begin
        hit0 = 1'b0; hit1 = 1'b0;
        settle();
        chk_outs("dropped_idle", '0);
        next_cyc();
      end
    end
    idle_inputs();
    chk_cnts("txn");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cyc();
    rst = 1'b0;
    n_hit = 0; n_miss = 0; n_wb = 0;
  endtask

  initial begin
    int r;
    rst = 1'b1;
    idle_inputs();
    lru = 1'b0; dirty0 = 1'b0; dirty1 = 1'b0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
    settle();
    chk_outs("reset_outs", '0);
    chk("reset_victim", 80'(victim), 80'd0);
    chk_cnts("reset");
    next_cyc();

    // Directed scenarios.
    txn(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);       // read hit way 1
    chk("read_hit_cnt", 80'(hit_cnt), 80'd1);
    txn(1'b1, 1'b0, 32'h0000_000F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0); // write hit way 0
    do_reset();
    txn(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 5, 1'b0);       // clean miss
    chk("clean_miss_cnt", 80'(miss_cnt), 80'd1);
    do_reset();
    txn(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 2, 1'b0);       // dirty miss
    chk("dirty_wb_cnt", 80'(wb_cnt), 80'd1);
    txn(1'b1, 1'b0, 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2, 2, 1'b1); // dropped mid-miss
    txn(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0); // rd+wr, double hit
    idle_cyc();

    // Randomized transactions.
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 5));
      txn(1'($urandom), 1'($urandom), $urandom,
          (r == 3) || (r == 5), (r == 4) || (r == 5),
          1'($urandom), 1'($urandom), 1'($urandom),
          int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
          ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 2) == 0) idle_cyc();
    end

    // Reset in the middle of a writeback.
    bus.mem_read = 1'b1; lru = 1'b1; dirty1 = 1'b1; dirty0 = 1'b0;
    hit0 = 1'b0; hit1 = 1'b0;
    next_cyc();
    next_cyc();
    settle();
    chk_outs("pre_rst_wb", e_wb(1'b1, 1'b0));
    next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    idle_inputs();
    n_hit = 0; n_miss = 0; n_wb = 0;
    settle();
    chk_outs("post_rst_outs", '0);
    chk("post_rst_victim", 80'(victim), 80'd0);
    chk_cnts("post_rst");
    next_cyc();
    txn(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 3, 1'b0);
    chk("post_rst_miss_cnt", 80'(miss_cnt), 80'd1);

    // Back-to-back hits wrap the 4-bit hit counter: 19 hits -> 3.
    do_reset();
    bus.mem_read = 1'b1; hit1 = 1'b1;
    for (int i = 0; i < 19; i++) begin
      settle();
      chk_outs("b2b_hit", e_hit(1'b0, 32'h0, 1'b1));
      next_cyc();
    end
    idle_inputs();
    chk("hit_wrap", 80'(hit_cnt), 80'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/l1_cache_control.md
Name: l1_cache_control

Overview:
- Control FSM for a 2-way set-associative, write-back, write-allocate L1 cache.
- Sequences two per-way byte-masked data arrays plus the tag/valid/dirty/LRU arrays, all with async read and sync write.
- Sits between the CPU-side memory port and the physical memory (pmem) port, in front of the L2/arbiter.
- Contains hit/miss/writeback performance counters.

Parameters:
- s_offset, 5, log2 of line size in bytes; s_mask = 2**s_offset byte enables per line.
- s_cnt, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable  in  s_mask  line-aligned CPU byte mask (from bus adapter)
- hit0, hit1  in  1  way tag match AND valid, combinational from datapath
- dirty0, dirty1  in  1  dirty bit of each way at current index
- lru  in  1  way to evict at current index
- pmem_resp  in  1  pmem transaction complete, 1-cycle pulse
- mem_resp  out  1  CPU request complete, 1-cycle pulse
- pmem_read, pmem_write  out  1  pmem requests, level, held until pmem_resp
- pmem_addr_sel  out  1  0 = CPU address (fill), 1 = victim tag address (writeback)
- victim  out  1  registered victim way for current miss
- way0_we, way1_we  out  s_mask  data array byte write enables
- data_sel  out  1  0 = CPU write data, 1 = pmem line
- tag_load0, tag_load1  out  1  load tag and set valid for way
- dirty_set0/1, dirty_clr0/1  out  1  dirty bit update per way
- lru_load  out  1  write lru_in
- lru_in  out  1  way to evict next
- hit_cnt, miss_cnt, wb_cnt  out  s_cnt  performance counters

Behaviour:
- Reset: state IDLE; victim 0; all counters 0; every combinational output 0 while in IDLE with no request.
- IDLE, no request: all outputs 0.
- IDLE, request and (hit0 or hit1) — hit, 0 extra cycles:
  - mem_resp = 1 the same cycle.
  - Hit way h = 0 if hit0, else 1; both asserted (illegal) → way 0 wins.
  - lru_load = 1, lru_in = ~h.
  - Write hit: way_h_we = mem_byte_enable, data_sel = 0, dirty_set_h = 1.
  - Read hit: no array writes.
  - hit_cnt += 1.
- IDLE, request, miss:
  - victim <= lru; miss_cnt += 1.
  - If dirty of lru way → WRITEBACK, else → FILL.
  - mem_resp = 0.
- WRITEBACK:
  - pmem_write = 1, pmem_addr_sel = 1.
  - On pmem_resp: dirty_clr_victim = 1, wb_cnt += 1, → FILL.
- FILL:
  - pmem_read = 1, pmem_addr_sel = 0.
  - On pmem_resp, same cycle: way_victim_we = all ones, data_sel = 1, tag_load_victim = 1, dirty_clr_victim = 1; → IDLE.
- Retry: the held request re-evaluates in IDLE the next cycle as a hit. Miss latency = 1 + pmem latencies + 1 cycles.
- Request dropped mid-miss (protocol violation): FSM still completes the fill and returns to IDLE; no mem_resp.
- pmem_resp in IDLE: ignored.
- mem_read and mem_write both high: treated as write.
- Counters: wrap modulo 2**s_cnt, no saturation.
- rst mid-operation: IDLE on the next edge; pmem_read/pmem_write low from that cycle; no array writes; counters cleared.
- Never writes both ways in one cycle; way_we nonzero only in a write-hit or a FILL-complete cycle.

Test Plan:
- Read hit: rst, then mem_read = 1, hit1 = 1 → mem_resp = 1 same cycle, lru_load = 1, lru_in = 0, way_we = 0, hit_cnt = 1.
- Write hit with mem_byte_enable = 0x0000_000F, hit0 = 1 → way0_we = 0x0000_000F, data_sel = 0, dirty_set0 = 1, lru_in = 1.
- Clean miss, lru = 1, dirty1 = 0, pmem_resp after 5 cycles:
  - pmem_read held 5 cycles, pmem_write never asserted.
  - Response cycle: way1_we = 0xFFFF_FFFF, data_sel = 1, tag_load1 = 1.
  - Next cycle hit1 = 1 → mem_resp; miss_cnt = 1.
- Dirty miss, lru = 0, dirty0 = 1:
  - pmem_write with pmem_addr_sel = 1 until pmem_resp, dirty_clr0 pulse, then pmem_read with pmem_addr_sel = 0.
  - wb_cnt = 1, miss_cnt = 1, total 1 mem_resp.
- rst asserted in WRITEBACK → next cycle pmem_write = 0, all counters 0; a later request behaves as from reset.
- Back-to-back hits, 2**s_cnt + 3 with s_cnt = 4 → hit_cnt wraps to 3.
